uart_rx_14bytes: RTL and testbench
==================================

UART_RX_14BYTES -- requirements
Module: uart_rx_14bytes

Interface
REQ-001 SHALL have parameter OVS, default 16: clk cycles per bit (clk = OVS x baud); legal values are even, 8..32.
REQ-002 SHALL have parameter GAP_BITS, default 4: maximum idle bit-times between bytes of one frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, sampling all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port data, output, 8 bits: last received byte.
REQ-007 SHALL have port addr, output, 4 bits: byte index 0..13 within the frame, valid with we.
REQ-008 SHALL have port we, output, 1 bit: one-cycle write strobe for data/addr.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a full 14-byte frame is received.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a framing error or inter-byte timeout.
REQ-011 SHALL have port busy, output, 1 bit: high from the first start bit until the frame completes or aborts.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-013 SHALL use frame format: start bit 0, 8 data bits LSB first, stop bit 1, no parity; extra idle-high bits between bytes are allowed.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: a falling edge of rxs (1 then 0) SHALL go to START and clear the sample counter.
REQ-016 START: at count OVS/2-1, rxs=0 SHALL go to DATA; rxs=1 SHALL be treated as a glitch, return to IDLE, and generate no error.
REQ-017 DATA: SHALL sample rxs every OVS clocks at mid-bit into shift bit 0..7, then go to STOP after bit 7.
REQ-018 STOP: OVS clocks after bit 7, rxs=1 SHALL drive data, addr=index, we=1 for one cycle, increment index, and return to IDLE.
REQ-019 STOP: rxs=0 SHALL pulse frame_err, set index=0, drop busy, and return to IDLE only after rxs=1 is seen, with no we.
REQ-020 SHALL pulse frame_done on the cycle after the we of index 13, then set index=0 and busy=0.
REQ-021 Inter-byte timeout: in IDLE with index!=0, an idle count reaching GAP_BITS*OVS clocks SHALL pulse frame_err and set index=0, busy=0; the count SHALL clear on every start.
REQ-022 SHALL keep we, frame_done and frame_err mutually exclusive within a cycle.
REQ-023 SHALL drop no byte when a start edge arrives on the cycle after STOP completes (back-to-back bytes, 1 stop bit).
REQ-024 SHALL hold data and addr between strobes.
REQ-025 SHALL have latency of at most OVS/2+3 clk from the mid-point of the stop bit on rx to we.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, counters=0, index=0, synchronizer flops=1, data=0, addr=0, we=0, frame_done=0, frame_err=0, busy=0.
REQ-027 Reset mid-frame SHALL discard the partial frame without emitting frame_err after release.
REQ-028 Reset release SHALL NOT be recognized as a start bit while rx is held low; the FSM SHALL wait for rxs=1 first.

Structure
REQ-029 SHALL place FSM state encoding, FRAME_BYTES=14 and the index width in a shared package uart14_pkg, usable by the TX side.
REQ-030 SHALL contain one sub-module, uart_rx_sync (2-flop synchronizer plus falling-edge detect).

Verification
REQ-031 Bench SHALL cover: OVS=16, 14 bytes 0x00..0x0D sent back-to-back with 2 stop bits -> 14 we with addr 0..13 matching data, then one frame_done, and no frame_err.
REQ-032 Bench SHALL cover: byte 0xA5 sent -> data=0xA5 (LSB first sampled as 1,0,1,0,0,1,0,1).
REQ-033 Bench SHALL cover: 5-clock low glitch on idle rx -> no we, no frame_err, busy stays 0.
REQ-034 Bench SHALL cover: stop bit forced 0 on byte 3 -> frame_err pulse, no we for addr 3; the next frame starts at addr 0.
REQ-035 Bench SHALL cover: 6 bytes then idle for 5 bit-times -> frame_err at 64 clk after the stop, and the next byte written at addr 0.
REQ-036 Bench SHALL cover: reset asserted during byte 7 -> all outputs 0 immediately; after release a complete frame is received correctly.

Source files
------------

// File: rtl/uart14_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart14_pkg
//  Description : Shared definitions for the 14-byte UART frame link
//                (receiver state encoding, frame length, byte index width).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart14_pkg;

    // Number of bytes in one frame and the width of the byte index
    localparam int FRAME_BYTES = 14;
    localparam int IDX_W       = $clog2(FRAME_BYTES);

    // Receiver bit-level state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the serial line plus falling-edge
//                detect. The edge detector only arms after the synchronizer
//                holds genuine samples and a real high level has been seen,
//                so a line held low through reset never looks like a start.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic rxs_o,
    output logic fall_o
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic [1:0] vld_q;

    // Synchronize rx and keep the previous trusted sample for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b0;
            vld_q  <= 2'b00;
        end else begin
            s1_q   <= rx_i;
            s2_q   <= s1_q;
            vld_q  <= {vld_q[0], 1'b1};
            prev_q <= vld_q[1] ? s2_q : 1'b0;
        end
    end

    assign rxs_o  = s2_q;
    assign fall_o = prev_q & ~s2_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_14bytes.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_14bytes
//  Description : UART receiver (8N1, OVS x oversampling) that assembles
//                14-byte frames, strobing each byte with its index and
//                flagging frame completion, stop-bit errors and gaps.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_14bytes
    import uart14_pkg::*;
#(
    parameter int OVS      = 16,
    parameter int GAP_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [7:0]       data,
    output logic [IDX_W-1:0] addr,
    output logic             we,
    output logic             frame_done,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W    = $clog2(OVS);
    localparam int GAP_CLKS = GAP_BITS * OVS;
    localparam int GAP_W    = $clog2(GAP_CLKS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

    logic rxs;
    logic rx_fall;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic             errw_q,  errw_d;
    logic [7:0]       data_q,  data_d;
    logic [IDX_W-1:0] addr_q,  addr_d;
    logic             we_q,    we_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;
    logic             busy_q,  busy_d;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .rx_i   (rx),
        .rxs_o  (rxs),
        .fall_o (rx_fall)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            errw_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            errw_q  <= errw_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        errw_d  = errw_q;
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;

        // Frame completes the cycle after the last byte's strobe; the index
        // has already wrapped to 0 when that strobe was issued.
        done_d = we_q && (addr_q == IDX_LAST);
        if (done_d) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Inter-byte gap watchdog, only while a frame is in progress
                if (idx_q != '0) begin
                    if (gap_q == GAP_LAST) begin
                        err_d  = 1'b1;
                        idx_d  = '0;
                        busy_d = 1'b0;
                        gap_d  = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end else begin
                    gap_d = '0;
                end
                if (rx_fall) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    gap_d   = '0;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!rxs) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        // Line went back high before mid start bit: a glitch
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (errw_q) begin
                    // After a bad stop bit, hold off until the line is idle
                    if (rxs) begin
                        state_d = ST_IDLE;
                        errw_d  = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        data_d  = shift_q;
                        addr_d  = idx_q;
                        we_d    = 1'b1;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                        state_d = ST_IDLE;
                    end else begin
                        err_d  = 1'b1;
                        idx_d  = '0;
                        busy_d = 1'b0;
                        errw_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data       = data_q;
    assign addr       = addr_q;
    assign we         = we_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_14bytes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_14bytes
//  Description : Directed + randomized bench for the 14-byte UART receiver,
//                with a frame-level reference model of expected writes,
//                frame completions and frame errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_14bytes;

    localparam int OVS      = 16;
    localparam int GAP_BITS = 4;
    localparam int NB       = 14;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic [3:0] addr;
    logic       we;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_rx_14bytes #(
        .OVS      (OVS),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .addr       (addr),
        .we         (we),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Observed activity, sampled on the falling edge
    int          cyc = 0;
    logic [11:0] obs_wr[$];
    int          obs_done = 0, obs_err = 0, excl_viol = 0, hold_viol = 0;
    int          busy_cyc = 0, we_cnt = 0, last_we_cyc = 0, last_err_cyc = 0;
    logic [7:0]  hold_d = 8'h00;
    logic [3:0]  hold_a = 4'h0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            if (we) begin
                obs_wr.push_back({addr, data});
                we_cnt++;
                last_we_cyc = cyc;
            end else if (data !== hold_d || addr !== hold_a) begin
                hold_viol++;
            end
            if (frame_done) obs_done++;
            if (frame_err) begin
                obs_err++;
                last_err_cyc = cyc;
            end
            if (int'(we) + int'(frame_done) + int'(frame_err) > 1) excl_viol++;
            if (busy) busy_cyc++;
        end
        hold_d = data;
        hold_a = addr;
    end

    // Frame-level reference model
    logic [11:0] exp_wr[$];
    int exp_idx = 0, exp_done = 0, exp_err = 0;

    task automatic model_good(input logic [7:0] b);
        exp_wr.push_back({4'(exp_idx), b});
        exp_idx++;
        if (exp_idx == NB) begin
            exp_idx = 0;
            exp_done++;
        end
    endtask

    task automatic model_bad_stop();
        exp_err++;
        exp_idx = 0;
    endtask

    task automatic model_timeout();
        if (exp_idx != 0) begin
            exp_err++;
            exp_idx = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [11:0] o;
        logic [11:0] e;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = (obs_wr.size() > 0) ? obs_wr.pop_front() : 12'hFFF;
            check({tag, "_wr"}, 32'(o), 32'(e));
        end
        check({tag, "_extra_we"}, 32'(obs_wr.size()), 32'd0);
        obs_wr.delete();
        check({tag, "_done_cnt"}, 32'(obs_done), 32'(exp_done));
        check({tag, "_err_cnt"}, 32'(obs_err), 32'(exp_err));
    endtask

    // Serial line drivers
    task automatic send_bit(input logic v);
        @(posedge clk);
        #1 rx = v;
        repeat (OVS - 1) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stops, input bit bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (bad) send_bit(1'b0);
        idle_bits(stops);
    endtask

    task automatic send_rand_frame();
        logic [7:0] b;
        for (int i = 0; i < NB; i++) begin
            b = 8'($urandom);
            send_byte(b, int'($urandom_range(3, 1)), 1'b0);
            model_good(b);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, 32'(data), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
        check({tag, "_err"}, 32'(frame_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    int         b0, w0, e0, dly;
    logic [7:0] rb;

    initial begin
        // Reset state
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;
        idle_bits(2);

        // Bytes 0x00..0x0D back-to-back with two stop bits
        for (int i = 0; i < NB; i++) begin
            send_byte(8'(i), 2, 1'b0);
            model_good(8'(i));
        end
        idle_bits(2);
        compare_all("seq14");

        // Single 0xA5 byte, then the frame times out
        send_byte(8'hA5, 1, 1'b0);
        model_good(8'hA5);
        idle_bits(1);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_addr", 32'(addr), 32'd0);
        idle_bits(6);
        model_timeout();
        compare_all("a5");

        // Short low glitch on an idle line
        b0 = busy_cyc;
        w0 = we_cnt;
        e0 = obs_err;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(3);
        check("glitch_busy", 32'(busy_cyc - b0), 32'd0);
        check("glitch_we", 32'(we_cnt - w0), 32'd0);
        check("glitch_err", 32'(obs_err - e0), 32'd0);

        // Bad stop bit on byte 3, then a full frame restarting at addr 0
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            send_byte(rb, 1, 1'b0);
            model_good(rb);
        end
        send_byte(8'($urandom), 1, 1'b1);
        model_bad_stop();
        idle_bits(2);
        compare_all("badstop");
        send_rand_frame();
        idle_bits(2);
        compare_all("after_bad");

        // Six bytes then five idle bit-times: gap timeout
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            send_byte(rb, 1, 1'b0);
            model_good(rb);
        end
        idle_bits(5);
        model_timeout();
        dly = last_err_cyc - last_we_cyc;
        check("timeout_delay_ok", 32'((dly >= 60 && dly <= 68) ? 1 : 0), 32'd1);
        rb = 8'($urandom);
        send_byte(rb, 1, 1'b0);
        model_good(rb);
        idle_bits(1);
        check("timeout_next_addr", 32'(addr), 32'd0);
        idle_bits(5);
        model_timeout();
        compare_all("timeout");

        // Reset during byte 7, then a clean frame
        for (int i = 0; i < 7; i++) begin
            rb = 8'($urandom);
            send_byte(rb, 1, 1'b0);
            model_good(rb);
        end
        compare_all("pre_reset");
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_idx = 0;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        idle_bits(2);
        send_rand_frame();
        idle_bits(6);
        compare_all("post_reset");

        // Reset released with the line held low
        @(posedge clk);
        #1 begin
            reset = 1'b0;
            rx    = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        b0 = busy_cyc;
        w0 = we_cnt;
        repeat (3 * OVS) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(2);
        check("lowrel_busy", 32'(busy_cyc - b0), 32'd0);
        check("lowrel_we", 32'(we_cnt - w0), 32'd0);
        rb = 8'($urandom);
        send_byte(rb, 1, 1'b0);
        model_good(rb);
        idle_bits(6);
        model_timeout();
        compare_all("lowrel");

        // Randomized full frames
        for (int f = 0; f < 2; f++) send_rand_frame();
        idle_bits(6);
        compare_all("rand");

        check("exclusive_strobes", 32'(excl_viol), 32'd0);
        check("hold_between_we", 32'(hold_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
